// File: rtl/keyb_fifo_pkg.sv
// Shared types and constants for the keyboard event FIFO.
// Provides the default event width, filter state encoding and timestamp width.
package keyb_fifo_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int TS_W      = 16;

    typedef enum logic {
        IDLE,
        QUAL
    } filt_state_e;

endpackage

// File: rtl/keyb_change_detect.sv
// Turns the level-style keyboard value into single-cycle push events.
// Ports: clk, reset (sync, high), keyb_char in; push pulse, acc_val out.
module keyb_change_detect
    import keyb_fifo_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int STABLE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] keyb_char,
    output logic             push,
    output logic [WIDTH-1:0] acc_val
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_q, push_d;
    filt_state_e      state_q, state_d;

    always_comb begin
        sync_d  = keyb_char;
        samp_d  = sync_q;
        cand_d  = cand_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        push_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (samp_q != last_q) begin
                    // A release to 0 re-arms the filter for the same key.
                    if (samp_q == '0) begin
                        last_d = '0;
                    end else if (STABLE_CYC == 1) begin
                        push_d = 1'b1;
                        last_d = samp_q;
                    end else begin
                        state_d = QUAL;
                        cand_d  = samp_q;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            QUAL: begin
                if (samp_q != cand_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
                    push_d  = 1'b1;
                    last_d  = cand_q;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            samp_q  <= '0;
            cand_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            push_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= sync_d;
            samp_q  <= samp_d;
            cand_q  <= cand_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            push_q  <= push_d;
            state_q <= state_d;
        end
    end

    assign push    = push_q;
    assign acc_val = last_q;

endmodule

// File: rtl/keyb_event_fifo.sv
// Key event FIFO: filters keyb_char into events, buffers them for memIO pops.
// Ports: clk, reset, keyb_char, rd_en, clr_ovf in; dout, empty, full, count,
// overflow out; ts out only when KEYB_FIFO_TIMESTAMP_EN is defined.
module keyb_event_fifo
    import keyb_fifo_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int STABLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         keyb_char,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef KEYB_FIFO_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]          ts
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic             push;
    logic [WIDTH-1:0] push_val;

    keyb_change_detect #(
        .WIDTH      (WIDTH),
        .STABLE_CYC (STABLE_CYC)
    ) u_detect (
        .clk       (clk),
        .reset     (reset),
        .keyb_char (keyb_char),
        .push      (push),
        .acc_val   (push_val)
    );

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop, drop;

    always_comb begin
        do_pop  = rd_en && !empty_q;
        // A pop frees the slot in the same cycle, so push-while-full is
        // only a drop when nothing is popped.
        do_push = push && (!full_q || do_pop);
        drop    = push && full_q && !do_pop;

        wr_ptr_d   = wr_ptr_q + PW'(do_push);
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = (overflow_q && !clr_ovf) || drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_val;
        end
    end

    assign dout     = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef KEYB_FIFO_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0] ts_mem_q [DEPTH];

    always_comb begin
        ts_cnt_d = ts_cnt_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ts_mem_q[wr_ptr_q] <= ts_cnt_q;
        end
    end

    assign ts = empty_q ? '0 : ts_mem_q[rd_ptr_q];
`endif

endmodule
